// File: rtl/ifetch_pkg.sv
// Shared types and address-split helpers for the instruction fetch stage.
package ifetch_pkg;

   typedef enum logic [0:0] {
      FETCH = 1'b0,
      MISS  = 1'b1
   } fetch_state_t;

   function automatic logic [31:0] addr_offset(input logic [31:0] pc, input int off_w);
      return pc & ((32'd1 << off_w) - 32'd1);
   endfunction

   function automatic logic [31:0] addr_index(input logic [31:0] pc, input int off_w,
                                              input int idx_w);
      return (pc >> off_w) & ((32'd1 << idx_w) - 32'd1);
   endfunction

   function automatic logic [31:0] addr_tag(input logic [31:0] pc, input int off_w,
                                            input int idx_w);
      return pc >> (off_w + idx_w);
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch bundles; flush drops every entry in one edge.
// Handshake: a push is taken when not full, or when full and an entry pops on the same edge.
module fetch_queue #(
   parameter int  DEPTH = 4,
   parameter type T     = logic [31:0],
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          push,
   input  T              push_data,
   input  logic          pop,
   output T              head,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   T               mem [DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic           do_push;
   logic           do_pop;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= bump(wr_ptr);
         if (do_pop)  rd_ptr <= bump(rd_ptr);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage is not reset; the consumer gates the head with empty.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: looks up FETCH_W words per cycle in a direct-mapped I-cache, queues bundles for decode.
// Decode handshake: the head transfers on any edge where out_valid && out_ready are both high.
module ifetch_unit
   import ifetch_pkg::*;
#(
   parameter int          FETCH_W    = 2,
   parameter int          LINES      = 4,
   parameter int          LINE_BYTES = 128,
   parameter int          QDEPTH     = 4,
   parameter logic [31:0] RESET_PC   = 32'h0,
   localparam int         OFF_W      = $clog2(LINE_BYTES),
   localparam int         IDX_W      = $clog2(LINES),
   localparam int         TAG_W      = 32 - OFF_W - IDX_W,
   localparam int         CW         = $clog2(QDEPTH + 1)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          redirect_valid,
   input  logic [31:0]                   redirect_pc,
   input  logic                          stall,
   input  logic [LINES*LINE_BYTES*8-1:0] cache_data,
   input  logic [LINES*TAG_W-1:0]        cache_tag,
   input  logic [LINES-1:0]              cache_v,
   output logic                          miss_req,
   output logic [31:0]                   miss_addr,
   input  logic                          miss_done,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [FETCH_W*32-1:0]         out_instr,
   output logic [FETCH_W*32-1:0]         out_pc,
   output logic [FETCH_W-1:0]            out_mask,
   output fetch_state_t                  dbg_state,
   output logic [CW-1:0]                 dbg_q_count
);

   localparam int LINE_BITS = LINE_BYTES * 8;

   typedef struct packed {
      logic [FETCH_W-1:0][31:0] instr;
      logic [FETCH_W-1:0][31:0] pc;
      logic [FETCH_W-1:0]       mask;
   } bundle_t;

   logic [31:0]          pc_q;
   fetch_state_t         state_q;
   logic [OFF_W-1:0]     off;
   logic [IDX_W-1:0]     idx;
   logic [TAG_W-1:0]     tag;
   logic [LINE_BITS-1:0] line;
   logic                 hit;
   bundle_t              lookup;
   bundle_t              head;
   logic [31:0]          adv;
   logic                 q_full;
   logic                 q_empty;
   logic                 push;
   logic                 pop;

   assign off  = OFF_W'(addr_offset(pc_q, OFF_W));
   assign idx  = IDX_W'(addr_index(pc_q, OFF_W, IDX_W));
   assign tag  = TAG_W'(addr_tag(pc_q, OFF_W, IDX_W));
   assign line = cache_data[int'(idx)*LINE_BITS +: LINE_BITS];
   assign hit  = cache_v[idx] && (cache_tag[int'(idx)*TAG_W +: TAG_W] == tag);

   // Slots past the line end stay zero so the bundle never crosses a line.
   always_comb begin
      lookup = '0;
      adv    = '0;
      for (int i = 0; i < FETCH_W; i++) begin
         if (int'(off) + 4*i < LINE_BYTES) begin
            lookup.mask[i] = 1'b1;
            lookup.pc[i]   = pc_q + 32'(4*i);
            for (int k = 0; k < 4; k++) begin
               lookup.instr[i][31-8*k -: 8] =
                  line[((int'(off) + 4*i + k) & (LINE_BYTES - 1))*8 +: 8];
            end
            adv = adv + 32'd4;
         end
      end
   end

   assign pop  = !q_empty && out_ready;
   assign push = (state_q == FETCH) && hit && !stall && !redirect_valid && (!q_full || pop);

   fetch_queue #(.DEPTH(QDEPTH), .T(bundle_t)) u_queue (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect_valid),
      .push      (push),
      .push_data (lookup),
      .pop       (pop),
      .head      (head),
      .full      (q_full),
      .empty     (q_empty),
      .count     (dbg_q_count)
   );

   assign out_valid = !q_empty;
   assign out_instr = q_empty ? '0 : head.instr;
   assign out_pc    = q_empty ? '0 : head.pc;
   assign out_mask  = q_empty ? '0 : head.mask;
   assign dbg_state = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q      <= RESET_PC;
         state_q   <= FETCH;
         miss_req  <= 1'b0;
         miss_addr <= '0;
      end else if (redirect_valid) begin
         pc_q     <= redirect_pc;
         state_q  <= FETCH;
         miss_req <= 1'b0;
      end else begin
         case (state_q)
            FETCH: begin
               if (!hit) begin
                  state_q   <= MISS;
                  miss_req  <= 1'b1;
                  miss_addr <= pc_q & ~32'(LINE_BYTES - 1);
               end else if (push) begin
                  pc_q <= pc_q + adv;
               end
            end
            MISS: begin
               if (miss_done) begin
                  state_q  <= FETCH;
                  miss_req <= 1'b0;
               end
            end
            default: state_q <= FETCH;
         endcase
      end
   end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Parametrised fetch stage that reads FETCH_W consecutive 32-bit instructions per cycle from a direct-mapped instruction cache and buffers them as bundles in a QDEPTH-entry queue toward decode. It handles line-end truncation, redirects (flushes), miss request/refill sequencing and a valid/ready decode handshake. It sits between the I-cache arrays and the decoder, replacing the fixed dual-issue fetch.

## Interface
- FETCH_W, 2: instructions per bundle (1..8)
- LINES, 4: cache lines (power of 2)
- LINE_BYTES, 128: bytes per line (power of 2, ≥ 4·FETCH_W)
- QDEPTH, 4: bundle queue depth (≥ 2)
- RESET_PC, 32'h0: fetch address after reset
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- redirect_valid  in  1  flush and restart at redirect_pc
- redirect_pc  in  32  new fetch address, 4-byte aligned
- stall  in  1  block enqueue of new bundles (branch hold)
- cache_data  in  LINES×LINE_BYTES×8  line bytes, byte 0 = lowest address
- cache_tag  in  LINES×TAG_W  TAG_W = 32 − log2(LINES) − log2(LINE_BYTES)
- cache_v  in  LINES  line valid
- miss_req  out  1  refill request
- miss_addr  out  32  line-aligned refill address
- miss_done  in  1  refill complete, line now valid
- out_valid  out  1  queue head valid
- out_ready  in  1  decoder accepts head
- out_instr  out  FETCH_W×32  instructions, slot 0 oldest
- out_pc  out  FETCH_W×32  per-slot PC
- out_mask  out  FETCH_W  slot valid

## Operation
- Address split: offset = pc[log2(LINE_BYTES)−1:0], index = next log2(LINES) bits, tag = rest. Hit = cache_v[index] && cache_tag[index]==tag.
- Big-endian word assembly: instr byte3 (MSB) = data[off], byte0 = data[off+3].
- Slot i valid iff off+4i < LINE_BYTES; bundle never crosses a line. Next pc = pc + 4·popcount(mask).
- FSM states: FETCH, MISS.
  - FETCH: on hit, !stall, queue can accept (not full, or full with pop this edge) → enqueue {instr, pc, mask}, advance pc. Hit but blocked → hold pc. Miss → MISS.
  - MISS: miss_req=1, miss_addr = pc with offset zeroed, held stable; on miss_done → FETCH, re-lookup next cycle.
- Redirect (any state): queue emptied, pc=redirect_pc, state FETCH, miss_req deasserted next edge; concurrent miss_done and enqueue ignored. Head transfer (out_valid && out_ready) in the redirect cycle still completes.
- stall does not block dequeue or redirect; in MISS it does not cancel the request.
- Slots with mask=0 drive out_instr=0, out_pc=0.

## Timing
- Reset values: out_valid=0, out_mask=0, out_instr=0, out_pc=0, miss_req=0, miss_addr=0; pc=RESET_PC, state FETCH, queue empty.
- Lookup combinational on pc; enqueue at edge; outputs from queue registers. Hit at pc in cycle N → out_valid with that bundle in cycle N+1.
- Redirect in cycle N → first bundle visible cycle N+2 on hit.
- Sustained throughput: one bundle/cycle with out_ready=1 and all hits.
- miss_req rises the cycle after the missing lookup; falls the cycle after miss_done.
- Queue full + pop same edge → push accepted; empty queue never pops.
- rst_n assertion clears all state immediately, mid-miss included.

## Structure
- ifetch_pkg: fetch_state_t enum {FETCH, MISS}; bundle_t struct (instr, pc, mask) parametrised via package constants or parametrised typedef in the module; functions addr_tag/addr_index/addr_offset.
- Sub-module fetch_queue: synchronous FIFO of bundle_t, DEPTH parameter, push/pop/flush, full/empty, count; flush and reset clear pointers.

## Test plan
- Line 0 valid tag 0, out_ready=1, release rst_n → cycle 2: out_pc={0x0,0x4}, mask 2'b11; then 0x8, 0x10, … one bundle/cycle.
- Redirect to 0x7C → bundle out_pc[0]=0x7C, mask 2'b01; next bundle pc 0x80, mask 2'b11.
- Redirect to 0x200, tag mismatch → miss_req=1, miss_addr=0x200 held 5 cycles; miss_done with line valid → bundle 0x200 two cycles later; no out_valid during miss after drain.
- out_ready=0 for 10 cycles from pc 0x0 → exactly 4 bundles queued (0x0–0x18), fetch pc held at 0x20; release yields 0x0… in order, no drops/duplicates.
- Redirect to 0x100 during MISS with simultaneous miss_done → miss_req low next cycle, queue empty, out_pc[0]=0x100 at N+2.
- rst_n low mid-miss with queue non-empty → out_valid, miss_req 0 immediately; after release fetch restarts at RESET_PC.
